spi_slave_port: RTL and testbench

- Mode-0 SPI slave endpoint that sits directly downstream of the Nios SPI master pins (SPI_sclk, SPI_ss, SPI_mosi, SPI_miso) on the board fabric.
- Oversamples the SPI lines in the sys_clk domain and deserialises MOSI into parallel words with a valid pulse.
- Serialises a preloaded transmit word onto MISO.
- Gives FPGA-side logic a register-style mailbox to the Nios.

---
 rtl/spi_slave_port_if.sv | 14 +
 rtl/spi_slave_port.sv | 114 +++++++++++
 tb/tb_spi_slave_port.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_port_if.sv
// spi_slave_port_if: SPI pins plus the rx/tx mailbox between the Nios SPI master and fabric logic
interface spi_slave_port_if #(parameter int DATA_WIDTH = 8);
    logic SPI_sclk, SPI_ss, SPI_mosi, SPI_miso, miso_oe;
    logic [DATA_WIDTH-1:0] rx_data, tx_data;
    logic rx_valid, rx_overrun, rx_ack, tx_load, tx_empty, busy;
    modport slave (
        input SPI_sclk, SPI_ss, SPI_mosi, rx_ack, tx_data, tx_load,
        output SPI_miso, miso_oe, rx_data, rx_valid, rx_overrun, tx_empty, busy
    );
    modport master (
        output SPI_sclk, SPI_ss, SPI_mosi, rx_ack, tx_data, tx_load,
        input SPI_miso, miso_oe, rx_data, rx_valid, rx_overrun, tx_empty, busy
    );
endinterface

// File: rtl/spi_slave_port.sv
// spi_slave_port: oversampled mode-0 SPI slave with rx/tx word mailbox
module spi_slave_port #(
    parameter int DATA_WIDTH = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic clk_clk,
    input logic reset_reset,
    spi_slave_port_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES:0] sclk_sr, ss_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;
    logic enter, leave, run;
    logic [DATA_WIDTH-2:0] shift_in;
    logic [DATA_WIDTH-1:0] word_nx, shift_out, hold, rx_data;
    logic [CNT_W-1:0] cnt;
    logic word_done, rx_valid, pending, rx_overrun, tx_empty;

    // SS history resets low so an SS already held low at reset release is not seen as a fall
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sclk_sr <= '0;
            ss_sr <= '0;
            mosi_sr <= '0;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-1:0], bus.SPI_sclk};
            ss_sr <= {ss_sr[SYNC_STAGES-1:0], bus.SPI_ss};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], bus.SPI_mosi};
        end
    end

    assign sclk_rise = sclk_sr[SYNC_STAGES-1] & ~sclk_sr[SYNC_STAGES];
    assign sclk_fall = ~sclk_sr[SYNC_STAGES-1] & sclk_sr[SYNC_STAGES];
    assign ss_fall = ~ss_sr[SYNC_STAGES-1] & ss_sr[SYNC_STAGES];
    assign ss_rise = ss_sr[SYNC_STAGES-1] & ~ss_sr[SYNC_STAGES];
    assign mosi_s = mosi_sr[SYNC_STAGES-1];

    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (ss_fall ? ACTIVE : IDLE) : (ss_rise ? IDLE : ACTIVE);
        enter = state == IDLE && ss_fall;
        leave = state == ACTIVE && ss_rise;
        run = state == ACTIVE && !ss_rise;
        word_nx = {shift_in, mosi_s};
    end

    // an unloaded holding register is sent as zeros; a coincident tx_load lands after the reload
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cnt <= '0;
            shift_in <= '0;
            shift_out <= '0;
            hold <= '0;
            tx_empty <= 1'b1;
            rx_data <= '0;
            word_done <= 1'b0;
            rx_valid <= 1'b0;
            pending <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            word_done <= 1'b0;
            rx_valid <= word_done;
            pending <= rx_valid | (pending & ~bus.rx_ack);
            if (bus.rx_ack && !pending)
                rx_overrun <= 1'b0;
            if (enter) begin
                cnt <= '0;
                shift_out <= tx_empty ? '0 : hold;
                tx_empty <= 1'b1;
            end else if (leave) begin
                cnt <= '0;
            end else if (run && sclk_rise) begin
                shift_in <= word_nx[DATA_WIDTH-2:0];
                if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt <= '0;
                    rx_data <= word_nx;
                    word_done <= 1'b1;
                    if (pending)
                        rx_overrun <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (run && sclk_fall) begin
                if (cnt == '0) begin
                    shift_out <= tx_empty ? '0 : hold;
                    tx_empty <= 1'b1;
                end else begin
                    shift_out <= shift_out << 1;
                end
            end
            if (bus.tx_load) begin
                hold <= bus.tx_data;
                tx_empty <= 1'b0;
            end
        end
    end

    assign bus.busy = state == ACTIVE;
    assign bus.miso_oe = state == ACTIVE;
    assign bus.SPI_miso = state == ACTIVE && shift_out[DATA_WIDTH-1];
    assign bus.rx_data = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.rx_overrun = rx_overrun;
    assign bus.tx_empty = tx_empty;
endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: directed vectors and corner-case sequences for 8- and 16-bit SPI slave ports
module tb_spi_slave_port;
    logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, mosi = 1'b0, ss8 = 1'b1, ss16 = 1'b1;
    int n_vec = 0, n_err = 0;
    logic [31:0] rxq8[$], rxq16[$];

    typedef struct {
        bit load;
        logic [31:0] tx;
        logic [31:0] mo;
        logic [31:0] exp_miso;
    } vec_t;
    vec_t tbl[4];

    spi_slave_port_if #(.DATA_WIDTH(8)) b8 ();
    spi_slave_port_if #(.DATA_WIDTH(16)) b16 ();

    spi_slave_port #(.DATA_WIDTH(8), .SYNC_STAGES(2)) u8 (.clk_clk(clk), .reset_reset(rst), .bus(b8));
    spi_slave_port #(.DATA_WIDTH(16), .SYNC_STAGES(2)) u16 (.clk_clk(clk), .reset_reset(rst), .bus(b16));

    assign b8.SPI_sclk = sclk;
    assign b8.SPI_mosi = mosi;
    assign b8.SPI_ss = ss8;
    assign b16.SPI_sclk = sclk;
    assign b16.SPI_mosi = mosi;
    assign b16.SPI_ss = ss16;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (b8.rx_valid)
            rxq8.push_back(32'(b8.rx_data));
        if (b16.rx_valid)
            rxq16.push_back(32'(b16.rx_data));
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required finish before 1ms");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rxd(input bit wide);
        return wide ? 32'(b16.rx_data) : 32'(b8.rx_data);
    endfunction

    function automatic logic [31:0] qsize(input bit wide);
        return wide ? 32'(rxq16.size()) : 32'(rxq8.size());
    endfunction

    task automatic load_tx(input bit wide, input logic [31:0] v);
        @(negedge clk);
        b8.tx_data = v[7:0];
        b16.tx_data = v[15:0];
        if (wide) b16.tx_load = 1'b1;
        else b8.tx_load = 1'b1;
        @(negedge clk);
        b8.tx_load = 1'b0;
        b16.tx_load = 1'b0;
    endtask

    task automatic ack(input bit wide);
        @(negedge clk);
        if (wide) b16.rx_ack = 1'b1;
        else b8.rx_ack = 1'b1;
        @(negedge clk);
        b8.rx_ack = 1'b0;
        b16.rx_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic ss_set(input bit wide, input logic v);
        @(negedge clk);
        if (wide) ss16 = v;
        else ss8 = v;
        repeat (6) @(negedge clk);
    endtask

    // SCLK = clk/8: MOSI changes while SCLK is low, MISO is sampled just before each rise
    task automatic shift_bits(input bit wide, input int n, input logic [31:0] mo, output logic [31:0] mi);
        mi = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = mo[i];
            repeat (4) @(negedge clk);
            mi = {mi[30:0], wide ? b16.SPI_miso : b8.SPI_miso};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic run_vec(input bit wide, input vec_t v);
        logic [31:0] mi;
        rxq8.delete();
        rxq16.delete();
        if (v.load) begin
            load_tx(wide, v.tx);
            chk("tx_empty_after_load", wide ? b16.tx_empty : b8.tx_empty, 0);
        end
        ss_set(wide, 1'b0);
        chk("tx_empty_after_ss_fall", wide ? b16.tx_empty : b8.tx_empty, 1);
        chk("busy_in_frame", wide ? b16.busy : b8.busy, 1);
        shift_bits(wide, wide ? 16 : 8, v.mo, mi);
        repeat (8) @(negedge clk);
        chk("miso_word", mi, v.exp_miso);
        chk("rx_data", rxd(wide), v.mo);
        chk("rx_valid_pulses", qsize(wide), 1);
        ss_set(wide, 1'b1);
        chk("busy_after_frame", wide ? b16.busy : b8.busy, 0);
        ack(wide);
        chk("overrun_clear", wide ? b16.rx_overrun : b8.rx_overrun, 0);
    endtask

    initial begin
        logic [31:0] mi_a, mi_b, mi;
        tbl[0] = '{1'b1, 32'hA5, 32'h3C, 32'hA5};
        tbl[1] = '{1'b1, 32'hFF, 32'h00, 32'hFF};
        tbl[2] = '{1'b1, 32'h00, 32'hFF, 32'h00};
        tbl[3] = '{1'b1, 32'h5A, 32'h96, 32'h5A};
        b8.rx_ack = 1'b0;
        b8.tx_load = 1'b0;
        b8.tx_data = '0;
        b16.rx_ack = 1'b0;
        b16.tx_load = 1'b0;
        b16.tx_data = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", b8.busy, 0);
        chk("reset_miso_oe", b8.miso_oe, 0);
        chk("reset_miso", b8.SPI_miso, 0);
        chk("reset_rx_data", rxd(0), 0);
        chk("reset_rx_valid", b8.rx_valid, 0);
        chk("reset_overrun", b8.rx_overrun, 0);
        chk("reset_tx_empty", b8.tx_empty, 1);
        chk("reset_tx_empty16", b16.tx_empty, 1);

        for (int i = 0; i < 4; i++)
            run_vec(0, tbl[i]);

        // two words in one frame, second tx word loaded mid-word-1, no acks -> overrun
        rxq8.delete();
        load_tx(0, 32'hC3);
        ss_set(0, 1'b0);
        shift_bits(0, 4, 32'h0, mi_a);
        load_tx(0, 32'h55);
        shift_bits(0, 4, 32'h1, mi_b);
        shift_bits(0, 8, 32'h02, mi);
        repeat (8) @(negedge clk);
        chk("b2b_miso_word1", {24'h0, mi_a[3:0], mi_b[3:0]}, 32'hC3);
        chk("b2b_miso_word2", mi, 32'h55);
        chk("b2b_valid_pulses", qsize(0), 2);
        if (rxq8.size() == 2) begin
            chk("b2b_first_word", rxq8[0], 32'h01);
            chk("b2b_second_word", rxq8[1], 32'h02);
        end
        chk("overrun_rx_data", rxd(0), 32'h02);
        chk("overrun_set", b8.rx_overrun, 1);
        ss_set(0, 1'b1);
        ack(0);
        chk("overrun_kept_on_pending_ack", b8.rx_overrun, 1);
        ack(0);
        chk("overrun_cleared", b8.rx_overrun, 0);

        // SS rises after 5 SCLK rises
        rxq8.delete();
        ss_set(0, 1'b0);
        shift_bits(0, 5, 32'h1F, mi);
        @(negedge clk);
        ss8 = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_oe_at_detect", b8.miso_oe, 1);
        @(negedge clk);
        chk("abort_oe_after", b8.miso_oe, 0);
        chk("abort_miso_after", b8.SPI_miso, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_valid", qsize(0), 0);
        chk("abort_rx_unchanged", rxd(0), 32'h02);
        run_vec(0, '{1'b1, 32'h69, 32'hF0, 32'h69});

        // reset with SS low after 3 bits; SS must cycle before the next frame
        load_tx(0, 32'h77);
        ss_set(0, 1'b0);
        shift_bits(0, 3, 32'h5, mi);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", b8.busy, 0);
        chk("rst_mid_oe", b8.miso_oe, 0);
        chk("rst_mid_miso", b8.SPI_miso, 0);
        chk("rst_mid_rx_data", rxd(0), 0);
        chk("rst_mid_overrun", b8.rx_overrun, 0);
        chk("rst_mid_tx_empty", b8.tx_empty, 1);
        rxq8.delete();
        shift_bits(0, 3, 32'h7, mi);
        repeat (8) @(negedge clk);
        chk("rst_mid_stays_idle", b8.busy, 0);
        chk("rst_mid_no_valid", qsize(0), 0);
        ss_set(0, 1'b1);
        run_vec(0, '{1'b0, 32'h0, 32'h81, 32'h00});

        run_vec(1, '{1'b0, 32'h0, 32'hBEEF, 32'h0000});
        run_vec(1, '{1'b1, 32'hBEEF, 32'hBEEF, 32'hBEEF});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
